// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings and byte-enable helper shared by the data memory
package dmem_pkg;
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_B ? 4'b0001 << a :
           size == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) :
           size == SZ_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: 4 x 8-bit byte-lane synchronous RAM, read-first
module dmem_bram #(
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wd,
  output logic [31:0]              rd
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
      rd_q <= mem[addr];
    end
  end

  assign rd = rd_q;
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte/half/word data memory with handshakes and faults; DMEM_PERF_EN adds access counters
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   off, wd, rd;
  logic          ill, mis, oor, fault, acc, en;
  logic [3:0]    we;
  logic [AW-1:0] widx;
  logic          rsp_valid_d, rsp_valid_q, err_d, err_q, ld_d, ld_q, uns_d, uns_q;
  logic [1:0]    size_d, size_q, lane_d, lane_q;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign req_ready = !rsp_valid_q || rsp_ready;

  // fault check, lane steering and RAM control; reset low blocks any write at the edge
  always_comb begin
    off   = req_addr - BASE_ADDR;
    ill   = req_size == 2'b11;
    mis   = (req_size == SZ_H && off[0]) || (req_size == SZ_W && off[1:0] != 2'b00);
    oor   = req_addr < BASE_ADDR || off[31:AW+2] != '0;
    fault = ill || mis || oor;
    acc   = rst_n && req_valid && req_ready;
    en    = acc && !fault;
    we    = req_we ? be_from_size(req_size, off[1:0]) : 4'b0000;
    wd    = req_size == SZ_B ? {4{req_wdata[7:0]}} :
            req_size == SZ_H ? {2{req_wdata[15:0]}} : req_wdata;
    widx  = off[AW+1:2];
  end

  dmem_bram #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_bram (
    .clk (clk),
    .en  (en),
    .we  (we),
    .addr(widx),
    .wd  (wd),
    .rd  (rd)
  );

  // response stage: capture on accept, drop once consumed
  always_comb begin
    rsp_valid_d = acc ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
    err_d       = acc ? fault : err_q;
    ld_d        = acc ? !fault && !req_we : ld_q;
    uns_d       = acc ? req_uns : uns_q;
    size_d      = acc ? req_size : size_q;
    lane_d      = acc ? off[1:0] : lane_q;
  end

  // response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ld_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      ld_q        <= ld_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
    end
  end

  // select the addressed lane from the RAM word and extend it
  always_comb begin
    byte_v    = rd[{lane_q, 3'b000} +: 8];
    half_v    = lane_q[1] ? rd[31:16] : rd[15:0];
    rsp_rdata = !ld_q ? 32'h0 :
                size_q == SZ_B ? {{24{!uns_q && byte_v[7]}}, byte_v} :
                size_q == SZ_H ? {{16{!uns_q && half_v[15]}}, half_v} : rd;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = err_q;

`ifdef DMEM_PERF_EN
  logic [31:0] loads_d, loads_q, stores_d, stores_q, errs_d, errs_q;

  // saturating per-class access counters
  always_comb begin
    loads_d  = loads_q  + 32'(acc && !fault && !req_we && loads_q  != '1);
    stores_d = stores_q + 32'(acc && !fault &&  req_we && stores_q != '1);
    errs_d   = errs_q   + 32'(acc && fault && errs_q != '1);
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_errs   = errs_q;
`endif
endmodule
